// File: rtl/grid_pkg.sv
// Shared types and defaults for the double-buffered Life grid store.
package grid_pkg;

    localparam int unsigned DEF_COLS = 8;
    localparam int unsigned DEF_ROWS = 8;

    typedef logic [DEF_COLS-1:0] row_t;

    // Controller states. BOOT covers the single cycle after reset release, where
    // LOAD_RUN is sampled to pick the first real state.
    typedef logic [1:0] mem_state_t;
    localparam mem_state_t BOOT      = 2'd0;
    localparam mem_state_t LOAD_FILL = 2'd1;
    localparam mem_state_t LOAD_FULL = 2'd2;
    localparam mem_state_t RUN       = 2'd3;

endpackage

// File: rtl/grid_bank.sv
// One ROWS x COLS register bank: a single write port plus a combinational
// three-row read port (centre row and its two toroidal neighbours).
module grid_bank
    import grid_pkg::*;
#(
    parameter int unsigned COLS   = DEF_COLS,
    parameter int unsigned ROWS   = DEF_ROWS,
    parameter int unsigned ADDR_W = $clog2(ROWS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [COLS-1:0]   wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [COLS-1:0]   rd_prev,
    output logic [COLS-1:0]   rd_cur,
    output logic [COLS-1:0]   rd_next
);

    localparam int unsigned    IDX_W    = $clog2(ROWS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

    logic [COLS-1:0]  mem [ROWS];
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] cur_idx;
    logic [IDX_W-1:0] prev_idx;
    logic [IDX_W-1:0] next_idx;
    logic             wr_in_range;

    assign wr_idx      = IDX_W'(wr_addr);
    assign cur_idx     = IDX_W'(rd_addr);
    assign wr_in_range = 32'(wr_addr) < ROWS;

    // Row storage; out-of-range write addresses are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < int'(ROWS); r++) begin
                mem[r] <= '0;
            end
        end else if (wr_en && wr_in_range) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Neighbour rows wrap around the top and bottom edges of the grid.
    always_comb begin
        prev_idx = (cur_idx == '0) ? LAST_IDX : cur_idx - 1'b1;
        next_idx = (cur_idx == LAST_IDX) ? '0 : cur_idx + 1'b1;
        rd_prev  = mem[prev_idx];
        rd_cur   = mem[cur_idx];
        rd_next  = mem[next_idx];
    end

endmodule

// File: rtl/grid_memory_banked.sv
// Ping-pong row store for the Life grid: the calculator reads the active bank
// while writing the next generation into the shadow bank; SWAP commits it.
// Load mode streams the initial pattern into the active bank row by row.
module grid_memory_banked
    import grid_pkg::*;
#(
    parameter int unsigned COLS   = DEF_COLS,
    parameter int unsigned ROWS   = DEF_ROWS,
    parameter int unsigned ADDR_W = $clog2(ROWS),
    parameter int unsigned GEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_run,
    input  logic [COLS-1:0]   initial_in,
    input  logic              initial_valid,
    output logic              initial_ready,
    output logic              load_done,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [COLS-1:0]   rd_prev,
    output logic [COLS-1:0]   rd_cur,
    output logic [COLS-1:0]   rd_next,
    output logic              rd_valid,
    input  logic [COLS-1:0]   grid_in,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              write_enable,
    input  logic              swap,
    output logic              active_bank,
    output logic [GEN_W-1:0]  gen_count
);

    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);

    mem_state_t        state_q;
    mem_state_t        state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;
    logic              active_q;
    logic [GEN_W-1:0]  gen_q;

    logic              load_xfer;
    logic              run_mode;
    logic              rd_in_range;

    logic [1:0]        bank_we;
    logic [ADDR_W-1:0] bank_addr [2];
    logic [COLS-1:0]   bank_data [2];
    logic [COLS-1:0]   bank_prev [2];
    logic [COLS-1:0]   bank_cur  [2];
    logic [COLS-1:0]   bank_next [2];

    assign run_mode      = (state_q == RUN);
    assign initial_ready = (state_q == LOAD_FILL);
    assign load_done     = (state_q == LOAD_FULL);
    assign load_xfer     = initial_ready && initial_valid;
    assign rd_in_range   = 32'(rd_addr) < ROWS;
    assign active_bank   = active_q;
    assign gen_count     = gen_q;

    // Next-state logic for the load/run controller and the load pointer.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            BOOT: begin
                state_d = load_run ? RUN : LOAD_FILL;
            end
            LOAD_FILL: begin
                if (load_xfer) begin
                    ptr_d = ptr_q + 1'b1;
                    if (ptr_q == LAST_ROW) begin
                        state_d = LOAD_FULL;
                    end
                end
                if (load_run) begin
                    state_d = RUN;
                end
            end
            LOAD_FULL: begin
                if (load_run) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!load_run) begin
                    state_d = LOAD_FILL;
                    ptr_d   = '0;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // Controller state and load pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Bank select and generation counter; leaving RUN restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            gen_q    <= '0;
        end else if (run_mode) begin
            if (swap) begin
                active_q <= ~active_q;
            end
            if (!load_run) begin
                gen_q <= '0;
            end else if (swap) begin
                gen_q <= gen_q + 1'b1;
            end
        end
    end

    // Write steering: loads target the active bank, run-mode writes the shadow.
    // A write coinciding with SWAP lands in the bank that becomes active.
    always_comb begin
        bank_we = '0;
        for (int b = 0; b < 2; b++) begin
            bank_addr[b] = '0;
            bank_data[b] = '0;
        end
        if (load_xfer) begin
            bank_we[active_q]   = 1'b1;
            bank_addr[active_q] = ptr_q;
            bank_data[active_q] = initial_in;
        end else if (run_mode && write_enable) begin
            bank_we[~active_q]   = 1'b1;
            bank_addr[~active_q] = wr_addr;
            bank_data[~active_q] = grid_in;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        grid_bank #(
            .COLS   (COLS),
            .ROWS   (ROWS),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (bank_we[b]),
            .wr_addr (bank_addr[b]),
            .wr_data (bank_data[b]),
            .rd_addr (rd_addr),
            .rd_prev (bank_prev[b]),
            .rd_cur  (bank_cur[b]),
            .rd_next (bank_next[b])
        );
    end

    // Registered read port; samples the pre-swap active bank and holds when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_prev  <= '0;
            rd_cur   <= '0;
            rd_next  <= '0;
            rd_valid <= 1'b0;
        end else if (run_mode && rd_en) begin
            rd_valid <= 1'b1;
            if (rd_in_range) begin
                rd_prev <= bank_prev[active_q];
                rd_cur  <= bank_cur[active_q];
                rd_next <= bank_next[active_q];
            end else begin
                rd_prev <= '0;
                rd_cur  <= '0;
                rd_next <= '0;
            end
        end else begin
            rd_valid <= 1'b0;
        end
    end

endmodule
